count_bcd_sequencer: RTL and testbench
======================================

# count_bcd_sequencer

Control block that paces the 12-bit up-counter and turns each new count into four BCD digits for the display path. It owns run/stop/clear control and a prescaler that issues single-cycle counter enables. It also contains an iterative shift-add-3 (double-dabble) binary-to-BCD converter, started after every counter update. It sits between the button/FSM front end and the counter-plus-display datapath.

## Interface
- TICK_DIV, 100000: clock cycles per count step; legal range is ≥ 16 so each conversion finishes before the next step.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; overrides all other inputs.
- start  in  1  single-cycle request to begin counting.
- stop  in  1  single-cycle request to pause counting.
- clear  in  1  single-cycle request to zero the counter and pause.
- count_in  in  12  current counter value, registered in the counter.
- cnt_en  out  1  one-cycle enable pulse to the counter.
- cnt_clr  out  1  one-cycle clear pulse to the counter.
- running  out  1  high while stepping is active.
- busy  out  1  high while the converter is in LOAD or SHIFT.
- bcd  out  16  {thousands, hundreds, tens, ones}, 4 bits each.
- bcd_valid  out  1  one-cycle pulse when bcd is updated.

## Operation
- All outputs are registered. While reset is low, every output and all internal state go to 0 at the next edge; bcd reads 0x0000.
- Command priority when inputs coincide: clear > stop > start.
- **start**
  - If idle, running goes 1 and the prescaler goes 0.
  - If already running, start is ignored and the prescaler is not restarted.
- **stop**
  - running goes 0 and the prescaler goes 0.
  - A conversion already in progress runs to completion.
- **clear**
  - cnt_clr pulses, running goes 0 and the prescaler goes 0.
  - Any in-progress conversion is aborted, and a new conversion is triggered by the cnt_clr pulse.
- **Prescaler**
  - Counts 0 to TICK_DIV-1 while running.
  - On the cycle after it reaches TICK_DIV-1, cnt_en=1 and the prescaler wraps to 0.
- **Converter FSM**, states CIDLE, LOAD, SHIFT, DONE:
  - Trigger: cnt_en or cnt_clr high in a cycle moves CIDLE → LOAD; the counter has updated by LOAD.
  - LOAD: captures count_in into the binary shift register, zeroes the 16-bit BCD scratch register and the iteration counter, then moves to SHIFT.
  - SHIFT, 12 cycles: each cycle, add 3 to every scratch nibble ≥ 5, then shift {scratch, binary} left by 1. After iteration 12 (index 11), move to DONE.
  - DONE: bcd holds the scratch value and bcd_valid=1 for this cycle only; then return to CIDLE.
- Width: the 12-bit maximum 4095 fits in 4 BCD digits; no overflow is possible.
- The counter's own wrap (4095 → 0) needs no special handling; the converter reports whatever count_in holds at LOAD.
- A trigger arriving in LOAD or SHIFT restarts from LOAD; this can only come from clear.

## Timing
- Start sampled at edge ending cycle S: running=1 from S+1; first cnt_en at cycle S+1+TICK_DIV, then every TICK_DIV cycles.
- Stop or clear sampled in cycle C: running=0 from C+1. For clear, cnt_clr=1 in cycle C+1.
- Trigger pulse (cnt_en or cnt_clr) in cycle E:
  - LOAD in E+1.
  - SHIFT in E+2 through E+13; busy=1 from E+1 through E+13.
  - DONE in E+14, with bcd valid and bcd_valid=1.
- Conversion latency is therefore 14 cycles from the trigger pulse to bcd_valid.
- A stop in cycle T suppresses any cnt_en scheduled at T+1 or later.
- Reset low mid-conversion: busy, bcd_valid and bcd are all 0 at the next edge, and no DONE follows.

## Test plan
1. **Reset and pacing.** TICK_DIV=16: hold reset low 3 cycles → all outputs 0. Pulse start at cycle S → cnt_en at S+17, S+33, S+49. bcd_valid 14 cycles after each cnt_en, showing 0x0001, 0x0002, 0x0003 (behavioural counter model).
2. **Conversion values.** Preset the model counter to 4094 and run one step → bcd=0x4095. Next step, with the model wrapping to 0 → bcd=0x0000. Preset 999 then step → 0x1000.
3. **Stop mid-conversion.** Stop 5 cycles after a cnt_en → bcd_valid still fires at E+14 with the correct value, no further cnt_en for 100 cycles, running=0. Start again → cnt_en 17 cycles later.
4. **Clear mid-conversion.** Clear at E+6 → cnt_clr at E+7, conversion restarts, bcd_valid at E+21 with bcd=0x0000, running=0, no bcd_valid at E+14.
5. **Simultaneous commands.**
   - start+stop+clear in one cycle → cnt_clr pulse, running stays 0.
   - start+stop while idle → running stays 0.
   - start while running → cnt_en phase unchanged.
6. **Reset mid-SHIFT.** Reset low at E+8 → next edge: busy=0, bcd=0x0000, running=0, no bcd_valid. After release, nothing happens until start.

Source files
------------

// File: rtl/count_bcd_sequencer.sv
// count_bcd_sequencer: run/stop/clear pacing of the up-counter plus iterative binary-to-BCD conversion
module count_bcd_sequencer #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [11:0] count_in,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        running,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        bcd_valid
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {CIDLE, LOAD, SHIFT, DONE} cstate_t;
  cstate_t state, state_n;
  logic [PW-1:0] presc;
  logic [11:0] bin, bin_n;
  logic [15:0] scr, scr_n, adj, bcd_n;
  logic [3:0] iter, iter_n;
  logic trig;
  assign trig = cnt_en | cnt_clr;
  // Run control with clear > stop > start priority; prescaler paces single-cycle counter enables
  always_ff @(posedge clk)
    if (!reset) begin
      running <= 1'b0;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      cnt_clr <= clear;
      cnt_en  <= running && presc == TOP && !stop && !clear;
      running <= (clear || stop) ? 1'b0 : (start || running);
      presc   <= (clear || stop || !running || presc == TOP) ? '0 : presc + PW'(1);
    end
  // Double-dabble step and converter next state; any trigger restarts from LOAD
  always_comb begin
    adj = scr;
    for (int i = 0; i < 4; i++)
      adj[4*i+:4] = scr[4*i+:4] >= 4'd5 ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
    state_n = state;
    bin_n   = bin;
    scr_n   = scr;
    iter_n  = iter;
    case (state)
      LOAD: begin
        bin_n   = count_in;
        scr_n   = '0;
        iter_n  = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        {scr_n, bin_n} = {adj, bin} << 1;
        iter_n  = iter + 4'd1;
        state_n = iter == 4'd11 ? DONE : SHIFT;
      end
      DONE:    state_n = CIDLE;
      default: state_n = CIDLE;
    endcase
    if (trig) state_n = LOAD;
    bcd_n = state_n == DONE ? scr_n : bcd;
  end
  // Converter registers; busy and bcd_valid are registered decodes of the next state
  always_ff @(posedge clk)
    if (!reset) begin
      state     <= CIDLE;
      bin       <= '0;
      scr       <= '0;
      iter      <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      state     <= state_n;
      bin       <= bin_n;
      scr       <= scr_n;
      iter      <= iter_n;
      bcd       <= bcd_n;
      busy      <= state_n == LOAD || state_n == SHIFT;
      bcd_valid <= state_n == DONE;
    end
endmodule

// File: tb/tb_count_bcd_sequencer.sv
// tb_count_bcd_sequencer: randomized self-checking bench with a behavioural counter and decimal-digit model
module tb_count_bcd_sequencer;
  localparam int TD = 16;
  logic clk = 0, reset = 0, start = 0, stop = 0, clear = 0;
  logic [11:0] cnt = 0, preset_val = 0;
  logic preset_req = 0;
  logic cnt_en, cnt_clr, running, busy, bcd_valid;
  logic [15:0] bcd;
  int compared = 0, mismatched = 0;

  count_bcd_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .count_in(cnt), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .running(running),
    .busy(busy), .bcd(bcd), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  // Behavioural 12-bit counter that the sequencer drives
  always @(posedge clk)
    if (!reset) cnt <= 0;
    else if (cnt_clr) cnt <= 0;
    else if (cnt_en) cnt <= cnt + 12'd1;
    else if (preset_req) cnt <= preset_val;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  function automatic logic sig(input int w);
    return w == 0 ? cnt_en : w == 1 ? bcd_valid : cnt_clr;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cmd(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    tick();
    start = 0; stop = 0; clear = 0;
  endtask

  task automatic preset(input int v);
    preset_val = 12'(v); preset_req = 1;
    tick();
    preset_req = 0;
  endtask

  task automatic wait_for(input int w, input int max, output int n);
    n = 0;
    while (!sig(w) && n < max) begin tick(); n++; end
    if (!sig(w)) n = -1;
  endtask

  task automatic do_step(output int ne, output int nv, output logic [15:0] got);
    cmd(1, 0, 0);
    wait_for(0, 100, ne);
    wait_for(1, 30, nv);
    got = bcd;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    compared++; if ({cnt_en, cnt_clr, running, busy, bcd_valid} !== 5'b0) begin mismatched++; $display("FAIL reset_ctrl: got %b want 00000", {cnt_en, cnt_clr, running, busy, bcd_valid}); end
    compared++; if (bcd !== 16'h0) begin mismatched++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
    reset = 1;
    tick();
  endtask

  task automatic test_pacing();
    int ne, nv;
    cmd(1, 0, 0);
    compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL pace_running: got %b want 1", running); end
    for (int k = 1; k <= 3; k++) begin
      wait_for(0, 100, ne);
      compared++; if (ne !== (k == 1 ? 16 : 1)) begin mismatched++; $display("FAIL pace_en_gap%0d: got %0d want %0d", k, ne, k == 1 ? 16 : 1); end
      wait_for(1, 30, nv);
      compared++; if (nv !== 14) begin mismatched++; $display("FAIL pace_latency%0d: got %0d want 14", k, nv); end
      compared++; if (bcd !== to_bcd(k)) begin mismatched++; $display("FAIL pace_bcd%0d: got %h want %h", k, bcd, to_bcd(k)); end
      tick();
      compared++; if (bcd_valid !== 1'b0) begin mismatched++; $display("FAIL pace_valid_pulse%0d: got %b want 0", k, bcd_valid); end
    end
  endtask

  task automatic test_values();
    int ne, nv, v;
    logic [15:0] got;
    cmd(0, 1, 0);
    preset(4094);
    do_step(ne, nv, got);
    compared++; if (ne !== 16 || nv !== 14) begin mismatched++; $display("FAIL val_4095_timing: got %0d/%0d want 16/14", ne, nv); end
    compared++; if (got !== 16'h4095) begin mismatched++; $display("FAIL val_4095: got %h want 4095", got); end
    wait_for(0, 40, ne);
    wait_for(1, 30, nv);
    compared++; if (ne !== 2 || bcd !== 16'h0000) begin mismatched++; $display("FAIL val_wrap: got gap %0d bcd %h want 2 0000", ne, bcd); end
    cmd(0, 1, 0);
    preset(999);
    do_step(ne, nv, got);
    compared++; if (got !== 16'h1000) begin mismatched++; $display("FAIL val_1000: got %h want 1000", got); end
    repeat (6) begin
      v = int'($urandom_range(4095, 0));
      cmd(0, 1, 0);
      preset(v);
      do_step(ne, nv, got);
      compared++; if (got !== to_bcd((v + 1) % 4096) || nv !== 14) begin mismatched++; $display("FAIL val_rand: preset %0d got %h lat %0d want %h lat 14", v, got, nv, to_bcd((v + 1) % 4096)); end
    end
  endtask

  task automatic test_stop_mid();
    int ne, nv, v, ens;
    logic [15:0] got;
    v = int'($urandom_range(4095, 0));
    cmd(0, 1, 0);
    preset(v);
    do_step(ne, nv, got);
    wait_for(0, 40, ne);
    repeat (5) tick();
    cmd(0, 1, 0);
    compared++; if (running !== 1'b0) begin mismatched++; $display("FAIL stop_running: got %b want 0", running); end
    wait_for(1, 30, nv);
    compared++; if (nv !== 8) begin mismatched++; $display("FAIL stop_latency: got %0d want 8", nv); end
    compared++; if (bcd !== to_bcd((v + 2) % 4096)) begin mismatched++; $display("FAIL stop_bcd: got %h want %h", bcd, to_bcd((v + 2) % 4096)); end
    ens = 0;
    repeat (100) begin tick(); if (cnt_en) ens++; end
    compared++; if (ens !== 0 || running !== 1'b0) begin mismatched++; $display("FAIL stop_quiet: got %0d enables running %b want 0 0", ens, running); end
    do_step(ne, nv, got);
    compared++; if (ne !== 16 || got !== to_bcd((v + 3) % 4096)) begin mismatched++; $display("FAIL stop_restart: got gap %0d bcd %h want 16 %h", ne, got, to_bcd((v + 3) % 4096)); end
  endtask

  task automatic test_clear_mid();
    int ne, first, nvalid;
    wait_for(0, 40, ne);
    repeat (6) tick();
    cmd(0, 0, 1);
    compared++; if (cnt_clr !== 1'b1 || running !== 1'b0) begin mismatched++; $display("FAIL clear_pulse: got clr %b running %b want 1 0", cnt_clr, running); end
    first = -1;
    nvalid = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (bcd_valid) begin nvalid++; if (first < 0) first = i; end
    end
    compared++; if (first !== 14 || nvalid !== 1) begin mismatched++; $display("FAIL clear_valid: got first %0d count %0d want 14 1", first, nvalid); end
    compared++; if (bcd !== 16'h0000 || running !== 1'b0) begin mismatched++; $display("FAIL clear_bcd: got %h running %b want 0000 0", bcd, running); end
  endtask

  task automatic test_simultaneous();
    int ne;
    repeat (3) tick();
    cmd(1, 1, 1);
    compared++; if (cnt_clr !== 1'b1 || running !== 1'b0) begin mismatched++; $display("FAIL sim_all: got clr %b running %b want 1 0", cnt_clr, running); end
    repeat (20) tick();
    cmd(1, 1, 0);
    compared++; if (running !== 1'b0 || cnt_clr !== 1'b0) begin mismatched++; $display("FAIL sim_start_stop: got running %b clr %b want 0 0", running, cnt_clr); end
    cmd(1, 0, 0);
    wait_for(0, 40, ne);
    compared++; if (ne !== 16) begin mismatched++; $display("FAIL sim_first_en: got %0d want 16", ne); end
    repeat (5) tick();
    cmd(1, 0, 0);
    wait_for(0, 40, ne);
    compared++; if (ne !== 10 || running !== 1'b1) begin mismatched++; $display("FAIL sim_restart_ignored: got gap %0d running %b want 10 1", ne, running); end
  endtask

  task automatic test_reset_mid();
    int ne, nv, act;
    logic [15:0] got;
    tick();
    wait_for(0, 40, ne);
    repeat (8) tick();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rst_busy_before: got %b want 1", busy); end
    reset = 0;
    tick();
    compared++; if ({busy, running, bcd_valid, cnt_en} !== 4'b0 || bcd !== 16'h0) begin mismatched++; $display("FAIL rst_mid: got %b bcd %h want 0000 0000", {busy, running, bcd_valid, cnt_en}, bcd); end
    reset = 1;
    act = 0;
    repeat (40) begin tick(); if (cnt_en || bcd_valid || busy || running) act++; end
    compared++; if (act !== 0) begin mismatched++; $display("FAIL rst_quiet: got %0d active cycles want 0", act); end
    do_step(ne, nv, got);
    compared++; if (ne !== 16 || got !== 16'h0001) begin mismatched++; $display("FAIL rst_resume: got gap %0d bcd %h want 16 0001", ne, got); end
  endtask

  initial begin
    test_reset();
    test_pacing();
    test_values();
    test_stop_mid();
    test_clear_mid();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
